// File: rtl/afe_spi_config_sequencer_pkg.sv
// rtl/afe_spi_config_sequencer_pkg.sv - shared opcodes, field positions, state type and defaults
// Package afe_cfg_pkg: imported by the interface, the SPI transmitter and the sequencer top.
package afe_cfg_pkg;

    localparam logic [3:0] OP_STOP     = 4'h0;
    localparam logic [3:0] OP_SEND     = 4'h1;

    localparam int         ROM_W       = 24;
    localparam int         OP_MSB      = 23;
    localparam int         OP_LSB      = 20;
    localparam int         PAYLOAD_W   = 20;

    localparam int         DEF_CLK_DIV = 4;
    localparam int         DEF_CS_GAP  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP,
        ST_DONE
    } seq_state_t;

endpackage

// File: rtl/afe_spi_config_sequencer_if.sv
// rtl/afe_spi_config_sequencer_if.sv - command ROM and AFE SPI pin bundle
// Signals: rom_address (to ROM), rom_command (from ROM, registered-address ROM),
//          spi_sclk / spi_cs_n / spi_mosi (to AFE, write-only 3-wire link).
// master: the sequencer; slave: the ROM plus AFE side.
interface afe_spi_config_sequencer_if
    import afe_cfg_pkg::*;
#(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] rom_address;
    logic [ROM_W-1:0]  rom_command;
    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;

    modport master (
        output rom_address,
        output spi_sclk,
        output spi_cs_n,
        output spi_mosi,
        input  rom_command
    );

    modport slave (
        input  rom_address,
        input  spi_sclk,
        input  spi_cs_n,
        input  spi_mosi,
        output rom_command
    );
endinterface

// File: rtl/afe_spi_tx.sv
// rtl/afe_spi_tx.sv - CMD_BITS-wide MSB-first SPI write frame with SCLK divider
// Ports: clk, reset_n (async, active-low); load + data start a frame;
//        busy high while bits are still being clocked out; finished pulses on the
//        cycle whose clock edge releases cs_n; sclk / cs_n / mosi are the pins.
// Frame: cs_n falls on the load edge, CMD_BITS sclk periods of 2*CLK_DIV, then
//        CLK_DIV cycles of hold with sclk low before cs_n rises.
module afe_spi_tx #(
    parameter int CLK_DIV  = 4,
    parameter int CMD_BITS = 20
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                load,
    input  logic [CMD_BITS-1:0] data,
    output logic                busy,
    output logic                finished,
    output logic                sclk,
    output logic                cs_n,
    output logic                mosi
);
    localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [4:0] LAST_BIT   = 5'(CMD_BITS - 1);

    // Holds only the bits still to be sent; the bit on mosi is already out.
    logic [CMD_BITS-2:0] shreg;
    logic [7:0]          div_cnt;
    logic [4:0]          bit_cnt;
    logic                shifting;
    logic                holding;
    logic                tick;

    assign tick     = (div_cnt == 8'd0);
    assign busy     = shifting;
    assign finished = holding && tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg    <= '0;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            shifting <= 1'b0;
            holding  <= 1'b0;
            sclk     <= 1'b0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
        end else if (load) begin
            shreg    <= data[CMD_BITS-2:0];
            mosi     <= data[CMD_BITS-1];
            div_cnt  <= DIV_RELOAD;
            bit_cnt  <= '0;
            shifting <= 1'b1;
            holding  <= 1'b0;
            sclk     <= 1'b0;
            cs_n     <= 1'b0;
        end else if (shifting) begin
            if (tick) begin
                div_cnt <= DIV_RELOAD;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    sclk    <= 1'b0;
                    bit_cnt <= bit_cnt + 5'd1;
                    if (bit_cnt == LAST_BIT) begin
                        // Last falling edge: mosi keeps the final bit through hold.
                        shifting <= 1'b0;
                        holding  <= 1'b1;
                    end else begin
                        mosi  <= shreg[CMD_BITS-2];
                        shreg <= {shreg[CMD_BITS-3:0], 1'b0};
                    end
                end
            end else begin
                div_cnt <= div_cnt - 8'd1;
            end
        end else if (holding) begin
            if (tick) begin
                cs_n    <= 1'b1;
                mosi    <= 1'b0;
                holding <= 1'b0;
            end else begin
                div_cnt <= div_cnt - 8'd1;
            end
        end
    end
endmodule

// File: rtl/afe_spi_config_sequencer.sv
// rtl/afe_spi_config_sequencer.sv - walks the AFE command ROM and sends each command over SPI
// Ports: clk, reset_n (async, active-low), start (one-cycle pulse), bus (master:
//        ROM address/command and SPI pins), busy, done (sticky), error (sticky).
// ROM words are {opcode[3:0], payload[19:0]}; OP_SEND sends one frame, OP_STOP
// ends cleanly, any other opcode or running off the last address ends with error.
module afe_spi_config_sequencer
    import afe_cfg_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int CS_GAP   = DEF_CS_GAP,
    parameter int ADDR_W   = 8,
    parameter int CMD_BITS = PAYLOAD_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       start,
    afe_spi_config_sequencer_if.master bus,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);
    localparam logic [7:0] GAP_RELOAD = 8'(CS_GAP - 1);

    seq_state_t        state;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        gap_cnt;
    logic [3:0]        opcode;
    logic              tx_load;
    logic              tx_busy;
    logic              tx_finished;
    logic              tx_sclk;
    logic              tx_cs_n;
    logic              tx_mosi;

    assign opcode  = bus.rom_command[OP_MSB:OP_LSB];
    // Loading on the DECODE edge makes cs_n fall together with the SHIFT state.
    assign tx_load = (state == ST_DECODE) && (opcode == OP_SEND);

    assign bus.rom_address = rom_address;
    assign bus.spi_sclk    = tx_sclk;
    assign bus.spi_cs_n    = tx_cs_n;
    assign bus.spi_mosi    = tx_mosi;

    afe_spi_tx #(
        .CLK_DIV  (CLK_DIV),
        .CMD_BITS (CMD_BITS)
    ) u_tx (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tx_load),
        .data     (bus.rom_command[CMD_BITS-1:0]),
        .busy     (tx_busy),
        .finished (tx_finished),
        .sclk     (tx_sclk),
        .cs_n     (tx_cs_n),
        .mosi     (tx_mosi)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            rom_address <= '0;
            gap_cnt     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        rom_address <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        error       <= 1'b0;
                        state       <= ST_FETCH;
                    end
                end
                // The ROM registers its address, so the word for the new
                // address is only visible one cycle later.
                ST_FETCH: state <= ST_DECODE;
                ST_DECODE: begin
                    case (opcode)
                        OP_SEND: state <= ST_SHIFT;
                        OP_STOP: begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            error <= 1'b0;
                            state <= ST_DONE;
                        end
                        default: begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            error <= 1'b1;
                            state <= ST_DONE;
                        end
                    endcase
                end
                // With CLK_DIV=1 the hold phase lasts a single cycle, so the
                // release can arrive while still in SHIFT; check it first.
                ST_SHIFT: begin
                    if (tx_finished) begin
                        gap_cnt <= GAP_RELOAD;
                        state   <= ST_GAP;
                    end else if (!tx_busy) begin
                        state <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (tx_finished) begin
                        gap_cnt <= GAP_RELOAD;
                        state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt == 8'd0) begin
                        if (&rom_address) begin
                            // Ran off the end of the ROM without a stop word.
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            error <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            rom_address <= rom_address + 1'b1;
                            state       <= ST_FETCH;
                        end
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
